time_display_scan: RTL and testbench

//  Reader side of the BCD time bus: takes the hour/minute/second/millisecond digits and drives a

---
 rtl/time_display_scan_pkg.sv | 23 ++
 rtl/time_display_scan_bcd_to_seg7.sv | 23 ++
 rtl/time_display_scan.sv | 80 ++++++++
 tb/tb_time_display_scan.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/time_display_scan_pkg.sv
// time_display_scan_pkg: segment patterns and digit indices shared by the time display scanner.
package time_display_scan_pkg;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [2:0] DIG_MS_L = 3'd0;
  localparam logic [2:0] DIG_MS_H = 3'd1;
  localparam logic [2:0] DIG_S_L = 3'd2;
  localparam logic [2:0] DIG_S_H = 3'd3;
  localparam logic [2:0] DIG_MIN_L = 3'd4;
  localparam logic [2:0] DIG_MIN_H = 3'd5;
  localparam logic [2:0] DIG_HR_L = 3'd6;
  localparam logic [2:0] DIG_HR_H = 3'd7;
endpackage

// File: rtl/time_display_scan_bcd_to_seg7.sv
// bcd_to_seg7: 4-bit BCD to active-low 7-segment pattern, dash for non-decimal nibbles.
module bcd_to_seg7
  import time_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/time_display_scan.sv
// time_display_scan: 8-digit multiplexed 7-segment scanner for the BCD time bus, with adjust-mode blink.
// Define TIME_SCAN_LZB_EN to blank a leading-zero hour tens digit.
module time_display_scan
  import time_display_scan_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] millisecond,
  input  logic [6:0] second,
  input  logic [6:0] minute,
  input  logic [5:0] hour,
  input  logic       adjust,
  input  logic [3:0] select,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [7:0] dig_en_n
);
  localparam int SLOT = CLK_HZ / SCAN_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW = SLOT > 1 ? $clog2(SLOT) : 1;
  localparam int BW = HALF > 1 ? $clog2(HALF) : 1;
  logic [PW-1:0] pre;
  logic [BW-1:0] bcnt;
  logic phase_off, tick, bterm, blink, lz;
  logic [2:0] idx, nidx;
  logic [27:0] snap, frame;
  logic [3:0] nib;
  logic [6:0] dseg;
  assign tick = pre == PW'(SLOT - 1);
  assign bterm = bcnt == BW'(HALF - 1);
  assign nidx = idx + 3'd1;
  // Digit 0 of a new frame must already come from the value being snapshotted on this edge.
  assign frame = (tick && nidx == DIG_MS_L) ? {hour, minute, second, millisecond} : snap;
  always_comb begin
    case (nidx)
      DIG_MS_L: nib = frame[3:0];
      DIG_MS_H: nib = frame[7:4];
      DIG_S_L: nib = frame[11:8];
      DIG_S_H: nib = {1'b0, frame[14:12]};
      DIG_MIN_L: nib = frame[18:15];
      DIG_MIN_H: nib = {1'b0, frame[21:19]};
      DIG_HR_L: nib = frame[25:22];
      default: nib = {2'b0, frame[27:26]};
    endcase
  end
  bcd_to_seg7 u_dec (.bcd(nib), .seg(dseg));
  assign blink = !adjust && !select[3] && select[2:0] == nidx && phase_off;
`ifdef TIME_SCAN_LZB_EN
  assign lz = nidx == DIG_HR_H && nib == 4'd0 && !(!adjust && select == {1'b0, DIG_HR_H});
`else
  assign lz = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (clr) begin
      pre <= '0;
      bcnt <= '0;
      phase_off <= 1'b0;
      idx <= '0;
      snap <= '0;
      seg_n <= SEG_BLANK;
      dp_n <= 1'b1;
      dig_en_n <= 8'hFF;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      bcnt <= bterm ? '0 : bcnt + 1'b1;
      if (bterm) phase_off <= ~phase_off;
      if (tick) begin
        idx <= nidx;
        if (nidx == DIG_MS_L) snap <= frame;
        seg_n <= (blink || lz) ? SEG_BLANK : dseg;
        dp_n <= blink || !(nidx == DIG_S_L || nidx == DIG_MIN_L || nidx == DIG_HR_L);
        dig_en_n <= ~(8'd1 << nidx);
      end
    end
  end
endmodule

// File: tb/tb_time_display_scan.sv
// tb_time_display_scan: vector table, corner sequences and random stimulus against a cycle-count reference model.
module tb_time_display_scan;
  localparam int P = 4;
  localparam int H = 8;
`ifdef TIME_SCAN_LZB_EN
  localparam logic [6:0] HT0 = 7'h7F;
`else
  localparam logic [6:0] HT0 = 7'h40;
`endif
  logic clk = 0, clr = 1;
  logic [7:0] millisecond = 0;
  logic [6:0] second = 0, minute = 0;
  logic [5:0] hour = 0;
  logic adjust = 1;
  logic [3:0] select = 0;
  logic [6:0] seg_n;
  logic dp_n;
  logic [7:0] dig_en_n;
  time_display_scan #(.CLK_HZ(16), .SCAN_HZ(4), .BLINK_HZ(1)) dut (
    .clk(clk), .clr(clr), .millisecond(millisecond), .second(second), .minute(minute),
    .hour(hour), .adjust(adjust), .select(select), .seg_n(seg_n), .dp_n(dp_n), .dig_en_n(dig_en_n)
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0, e = 0;
  int s_h = 0, s_m = 0, s_s = 0, s_ms = 0;
  logic [6:0] m_seg = 7'h7F;
  logic m_dp = 1;
  logic [7:0] m_dig = 8'hFF;
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
    end
  endtask
  function automatic int digit_val(int i);
    case (i)
      0: return s_ms % 16;
      1: return s_ms / 16;
      2: return s_s % 16;
      3: return s_s / 16;
      4: return s_m % 16;
      5: return s_m / 16;
      6: return s_h % 16;
      default: return s_h / 16;
    endcase
  endfunction
  task automatic step();
    int i, v;
    logic bl, lz;
    @(posedge clk);
    #1;
    if (clr) begin
      e = 0;
      s_h = 0; s_m = 0; s_s = 0; s_ms = 0;
      m_seg = 7'h7F; m_dp = 1; m_dig = 8'hFF;
    end else begin
      e++;
      if (e % P == 0) begin
        i = (e / P) % 8;
        if (i == 0) begin
          s_h = hour; s_m = minute; s_s = second; s_ms = millisecond;
        end
        v = digit_val(i);
        bl = !adjust && select < 8 && select == i && ((e - 1) / H) % 2 == 1;
`ifdef TIME_SCAN_LZB_EN
        lz = i == 7 && v == 0 && !(!adjust && select == 7);
`else
        lz = 0;
`endif
        m_seg = (bl || lz) ? 7'h7F : (v <= 9 ? pat[v] : 7'h3F);
        m_dp = bl || !(i == 2 || i == 4 || i == 6);
        m_dig = ~(8'd1 << i);
      end
    end
    check("scan", {seg_n, dp_n, dig_en_n}, {m_seg, m_dp, m_dig});
  endtask
  task automatic wait_digit(int d, output logic ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = e % P == 0 && dig_en_n == ~(8'd1 << d);
    end
    if (!ok) check("digit_timeout", 16'(d), 16'hFFFF);
  endtask
  typedef struct {
    logic [5:0] h; logic [6:0] m; logic [6:0] s; logic [7:0] ms;
    logic adj; logic [3:0] sel; int dig; logic [6:0] seg; logic dp;
  } vec_t;
  vec_t vt[$];
  initial begin
    logic ok;
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 0, 7'h78, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 1, 7'h02, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 2, 7'h10, 1'b0});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 3, 7'h12, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 4, 7'h12, 1'b0});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 5, 7'h19, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 6, 7'h30, 1'b0});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 7, 7'h24, 1'b1});
    vt.push_back('{6'h23, 7'h4C, 7'h59, 8'h67, 1'b1, 4'd0, 4, 7'h3F, 1'b0});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b0, 4'd4, 4, 7'h7F, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b0, 4'd1, 1, 7'h02, 1'b1});
    vt.push_back('{6'h23, 7'h45, 7'h59, 8'h67, 1'b0, 4'd9, 4, 7'h12, 1'b0});
    vt.push_back('{6'h05, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 7, HT0, 1'b1});
    vt.push_back('{6'h05, 7'h45, 7'h59, 8'h67, 1'b1, 4'd0, 6, 7'h12, 1'b0});
    vt.push_back('{6'h05, 7'h45, 7'h59, 8'h67, 1'b0, 4'd7, 7, 7'h7F, 1'b1});
    clr = 1;
    repeat (3) step();
    clr = 0;
    check("reset", {seg_n, dp_n, dig_en_n}, {7'h7F, 1'b1, 8'hFF});
    repeat (2) step();
    check("blank_before_tick", {seg_n, dp_n, dig_en_n}, {7'h7F, 1'b1, 8'hFF});
    repeat (2 * 8 * P) step();
    foreach (vt[j]) begin
      hour = vt[j].h; minute = vt[j].m; second = vt[j].s; millisecond = vt[j].ms;
      adjust = vt[j].adj; select = vt[j].sel;
      clr = 1;
      step();
      clr = 0;
      repeat (8 * P) step();
      wait_digit(vt[j].dig, ok);
      if (ok) check($sformatf("vec%0d", j), {7'b0, seg_n, dp_n, 1'b0}, {7'b0, vt[j].seg, vt[j].dp, 1'b0});
    end
    hour = 6'h23; minute = 7'h45; second = 7'h59; millisecond = 8'h67; adjust = 1;
    clr = 1;
    step();
    clr = 0;
    repeat (8 * P) step();
    wait_digit(3, ok);
    millisecond = 8'h68;
    wait_digit(7, ok);
    check("tear_hr_h", {9'b0, seg_n}, {9'b0, 7'h24});
    wait_digit(0, ok);
    check("next_frame_ms_l", {9'b0, seg_n}, {9'b0, 7'h00});
    wait_digit(5, ok);
    clr = 1;
    step();
    clr = 0;
    check("clr_mid_frame", {seg_n, dp_n, dig_en_n}, {7'h7F, 1'b1, 8'hFF});
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        hour = 6'($urandom); minute = 7'($urandom); second = 7'($urandom); millisecond = 8'($urandom);
      end
      if ($urandom_range(0, 29) == 0) adjust = 1'($urandom);
      if ($urandom_range(0, 19) == 0) select = 4'($urandom);
      clr = $urandom_range(0, 299) == 0;
      step();
    end
    clr = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
